qam16_rx_checker: RTL and testbench

Receive-side counterpart of the 16-QAM transmit chain (PRBS symbol source plus mapper). It slices incoming signed I/Q samples back to 4-bit symbols and aligns them to the transmitted reference symbol stream by searching for the channel delay. Once aligned, it counts symbol errors over fixed windows. It runs in the 25 MHz system domain, qualified by the symbol-rate enable from clk_gen, and is used for loopback and BER measurement.

---
 rtl/qam16_rx_checker.sv | 152 +++++++++++++++
 tb/tb_qam16_rx_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_rx_checker.sv
// 16-QAM receive checker: slices I/Q to Gray-coded symbols, searches the channel
// delay against the reference symbol stream, then counts symbol errors per window.
module qam16_rx_checker #(
  parameter int WIDTH      = 18,
  parameter int MAX_DELAY  = 16,
  parameter int LOCK_COUNT = 32,
  parameter int LOSS_COUNT = 8,
  parameter int WINDOW_LEN = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic [WIDTH-1:0]             in_phs_sig,
  input  logic [WIDTH-1:0]             quad_sig,
  input  logic [WIDTH-2:0]             thresh,
  input  logic [3:0]                   ref_sym,
  output logic [3:0]                   sym_out,
  output logic                         sym_valid,
  output logic                         locked,
  output logic [$clog2(MAX_DELAY)-1:0] delay,
  output logic [23:0]                  err_count,
  output logic [23:0]                  err_last,
  output logic                         window_done
);

  localparam int DW = $clog2(MAX_DELAY);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int SW = $clog2(WINDOW_LEN + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state, state_nx;
  logic [3:0]    hist [MAX_DELAY];
  logic [MW-1:0] match_cnt, match_nx;
  logic [LW-1:0] miss_cnt, miss_nx;
  logic [SW-1:0] sym_cnt, sym_nx;
  logic [DW-1:0] delay_nx;
  logic [23:0]   err_nx, last_nx, err_sum;
  logic          done_nx;
  logic          match;

  // Magnitude kept in WIDTH bits: the most negative input maps to 2^(WIDTH-1),
  // which always exceeds thresh and therefore slices as outer.
  function automatic logic [1:0] slice(input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-2:0] th);
    logic [WIDTH-1:0] mag;
    mag = x[WIDTH-1] ? (~x + 1'b1) : x;
    return {~x[WIDTH-1], (mag < {1'b0, th})};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      sym_out   <= '0;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= clk_en;
      if (clk_en)
        sym_out <= {slice(in_phs_sig, thresh), slice(quad_sig, thresh)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < MAX_DELAY; k++)
        hist[k] <= '0;
    end else if (clk_en) begin
      hist[0] <= ref_sym;
      for (int unsigned k = 1; k < MAX_DELAY; k++)
        hist[k] <= hist[k-1];
    end
  end

  assign match = (sym_out == hist[delay]);

  always_comb begin
    state_nx = state;
    delay_nx = delay;
    match_nx = match_cnt;
    miss_nx  = miss_cnt;
    sym_nx   = sym_cnt;
    err_nx   = err_count;
    last_nx  = err_last;
    done_nx  = 1'b0;
    err_sum  = err_count;
    if (!match && (err_count != '1))
      err_sum = err_count + 24'd1;

    if (sym_valid) begin
      if (state == HUNT) begin
        if (match) begin
          if (match_cnt == MW'(LOCK_COUNT - 1)) begin
            state_nx = LOCKED;
            match_nx = '0;
            err_nx   = '0;
            sym_nx   = '0;
          end else begin
            match_nx = match_cnt + 1'b1;
          end
        end else begin
          match_nx = '0;
          delay_nx = delay + 1'b1;
        end
      end else begin
        miss_nx = match ? '0 : miss_cnt + 1'b1;
        if (sym_cnt == SW'(WINDOW_LEN - 1)) begin
          last_nx = err_sum;
          done_nx = 1'b1;
          err_nx  = '0;
          sym_nx  = '0;
        end else begin
          err_nx  = err_sum;
          sym_nx  = sym_cnt + 1'b1;
        end
        // Loss of lock overrides the counters after any window completion above.
        if (!match && (miss_cnt == LW'(LOSS_COUNT - 1))) begin
          state_nx = HUNT;
          delay_nx = delay + 1'b1;
          match_nx = '0;
          miss_nx  = '0;
          sym_nx   = '0;
          err_nx   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= HUNT;
      delay       <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      sym_cnt     <= '0;
      err_count   <= '0;
      err_last    <= '0;
      window_done <= 1'b0;
    end else begin
      state       <= state_nx;
      delay       <= delay_nx;
      match_cnt   <= match_nx;
      miss_cnt    <= miss_nx;
      sym_cnt     <= sym_nx;
      err_count   <= err_nx;
      err_last    <= last_nx;
      window_done <= done_nx;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_qam16_rx_checker.sv
// Scoreboard bench for qam16_rx_checker: random reference symbols through a
// delayed, optionally corrupted loopback channel.
module tb_qam16_rx_checker;

  localparam int W = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_en = 1'b0;
  logic [W-1:0]  in_phs_sig = '0;
  logic [W-1:0]  quad_sig = '0;
  logic [W-2:0]  thresh = 17'h04000;
  logic [3:0]    ref_sym = '0;
  logic [3:0]    sym_out;
  logic          sym_valid;
  logic          locked;
  logic [3:0]    delay;
  logic [23:0]   err_count;
  logic [23:0]   err_last;
  logic          window_done;

  always #5 clk = ~clk;

  qam16_rx_checker #(
    .WIDTH(18), .MAX_DELAY(16), .LOCK_COUNT(32), .LOSS_COUNT(8), .WINDOW_LEN(1024)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_phs_sig(in_phs_sig), .quad_sig(quad_sig), .thresh(thresh),
    .ref_sym(ref_sym), .sym_out(sym_out), .sym_valid(sym_valid),
    .locked(locked), .delay(delay), .err_count(err_count),
    .err_last(err_last), .window_done(window_done)
  );

  logic [4:0] sb[$];
  logic [3:0] txh [32];
  int  n_vec = 0;
  int  n_err = 0;
  int  chan_delay = 0;
  int  corrupt_n = 0;
  int  sv_cnt = 0;
  int  bad_run = 0;
  bit  stream = 1'b0;
  bit  wd_seen = 1'b0;

  logic [W-1:0] sl_in  [7] = '{18'h06000, 18'h04000, 18'h03FFF, 18'h00000,
                               18'h3FFFF, 18'h3C000, 18'h20000};
  logic [1:0]   sl_exp [7] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lvl(input logic [1:0] b);
    case (b)
      2'b10:   return 18'h06000;
      2'b11:   return 18'h02000;
      2'b01:   return 18'h3E000;
      default: return 18'h3A000;
    endcase
  endfunction

  task automatic tick();
    logic [3:0] r, tx;
    logic       bad;
    logic [4:0] e;
    @(posedge clk);
    #1;
    if (stream) begin
      r = 4'($urandom_range(0, 15));
      for (int k = 31; k > 0; k--) txh[k] = txh[k-1];
      txh[0] = r;
      tx  = txh[chan_delay];
      bad = 1'b0;
      if (corrupt_n > 0) begin
        tx[3] = ~tx[3];
        bad   = 1'b1;
        corrupt_n--;
      end
      ref_sym    = r;
      in_phs_sig = lvl(tx[3:2]);
      quad_sig   = lvl(tx[1:0]);
      clk_en     = 1'b1;
      sb.push_back({bad, tx});
    end
    @(negedge clk);
    wd_seen = window_done;
    if (sym_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_valid", {31'd0, sym_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("sym", {28'd0, sym_out}, {28'd0, e[3:0]});
        sv_cnt++;
        bad_run = e[4] ? bad_run + 1 : 0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    stream = 1'b0;
    clk_en = 1'b0;
    reset  = 1'b0;
    repeat (n) tick();
    sb.delete();
    for (int k = 0; k < 32; k++) txh[k] = '0;
    reset   = 1'b1;
    sv_cnt  = 0;
    bad_run = 0;
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int t;
    t = 0;
    while (!locked && t < budget) begin
      tick();
      t++;
    end
    check_val(tag, {31'd0, locked}, 32'd1);
  endtask

  task automatic wait_window(input string tag, input logic [23:0] exp);
    int t;
    t = 0;
    tick();
    while (!wd_seen && t < 1200) begin
      tick();
      t++;
    end
    check_val({tag, "_seen"}, {31'd0, wd_seen}, 32'd1);
    check_val(tag, {8'd0, err_last}, {8'd0, exp});
  endtask

  initial begin
    int sv0;
    for (int k = 0; k < 32; k++) txh[k] = '0;

    // Reset state
    do_reset(5);
    check_val("rst_sym_out", {28'd0, sym_out}, 32'd0);
    check_val("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
    check_val("rst_locked", {31'd0, locked}, 32'd0);
    check_val("rst_delay", {28'd0, delay}, 32'd0);
    check_val("rst_err_count", {8'd0, err_count}, 32'd0);
    check_val("rst_err_last", {8'd0, err_last}, 32'd0);
    check_val("rst_window_done", {31'd0, window_done}, 32'd0);

    // Slicer boundaries, with idle gaps between strobes
    quad_sig = lvl(2'b11);
    ref_sym  = 4'h0;
    for (int i = 0; i < 7; i++) begin
      in_phs_sig = sl_in[i];
      clk_en     = 1'b1;
      sb.push_back({1'b0, sl_exp[i], 2'b11});
      tick();
      clk_en = 1'b0;
      tick();
    end
    check_val("slicer_drained", sb.size(), 32'd0);
    check_val("slicer_no_lock", {31'd0, locked}, 32'd0);

    // Zero-delay lock: exactly LOCK_COUNT clean comparisons
    do_reset(2);
    chan_delay = 0;
    stream     = 1'b1;
    for (int t = 0; t < 100 && sv_cnt < 32; t++) begin
      tick();
      check_val("pre_lock", {31'd0, locked}, 32'd0);
    end
    check_val("lock0_count", sv_cnt, 32'd32);
    tick();
    check_val("lock0_locked", {31'd0, locked}, 32'd1);
    check_val("lock0_delay", {28'd0, delay}, 32'd0);

    // Delay 5, clean windows
    do_reset(2);
    chan_delay = 5;
    stream     = 1'b1;
    wait_lock("lock5", 3000);
    check_val("lock5_delay", {28'd0, delay}, 32'd5);
    wait_window("win_clean0", 24'd0);
    sv0 = sv_cnt;
    wait_window("win_clean1", 24'd0);
    check_val("win_len", sv_cnt - sv0, 32'd1024);

    // Three isolated errors inside one window
    repeat (10) tick();
    corrupt_n = 1;
    repeat (10) tick();
    corrupt_n = 1;
    repeat (10) tick();
    corrupt_n = 1;
    repeat (5) tick();
    check_val("err_count3", {8'd0, err_count}, 32'd3);
    check_val("err_still_locked", {31'd0, locked}, 32'd1);
    wait_window("win_err3", 24'd3);

    // Loss of lock on 8 consecutive corrupted symbols
    corrupt_n = 8;
    for (int t = 0; t < 20 && bad_run < 8; t++) tick();
    check_val("loss_run", bad_run, 32'd8);
    check_val("loss_hold", {31'd0, locked}, 32'd1);
    tick();
    check_val("loss_locked", {31'd0, locked}, 32'd0);
    check_val("loss_delay", {28'd0, delay}, 32'd6);
    check_val("loss_err_last", {8'd0, err_last}, 32'd3);
    check_val("loss_err_count", {8'd0, err_count}, 32'd0);
    wait_lock("relock", 1000);
    check_val("relock_delay", {28'd0, delay}, 32'd5);
    check_val("relock_err_last", {8'd0, err_last}, 32'd3);

    // Reset while locked
    do_reset(2);
    check_val("mid_rst_locked", {31'd0, locked}, 32'd0);
    check_val("mid_rst_delay", {28'd0, delay}, 32'd0);
    check_val("mid_rst_err_count", {8'd0, err_count}, 32'd0);
    check_val("mid_rst_err_last", {8'd0, err_last}, 32'd0);
    check_val("mid_rst_sym_out", {28'd0, sym_out}, 32'd0);
    check_val("mid_rst_sym_valid", {31'd0, sym_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
